// File: rtl/backing_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : backing_memory
// Purpose  : Line-granular backing store for a cache. Each request is
//            serviced once with a fixed latency: line fills return stored
//            data, and line writebacks commit data and echo it back.
// Ports    : clk             - single clock, all state on the rising edge
//            rst             - asynchronous, active-low reset
//            reqValid_MEM    - request valid, held until the response is seen
//            reqAddress_MEM  - byte address of the line
//            reqWen_MEM      - 1 = writeback, 0 = fill
//            reqDataIn_MEM   - writeback line data
//            respDataOut_MEM - fill data / writeback echo, held between
//                              responses
//            respReady_MEM   - one-cycle completion pulse
//            txnCount_MEM    - completed-transaction counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module backing_memory #(
  parameter int LINE_WORDS  = 4,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reqValid_MEM,
  input  logic [31:0]             reqAddress_MEM,
  input  logic                    reqWen_MEM,
  input  logic [32*LINE_WORDS-1:0] reqDataIn_MEM,
  output logic [32*LINE_WORDS-1:0] respDataOut_MEM,
  output logic                    respReady_MEM,
  output logic [15:0]             txnCount_MEM
);

  localparam int c_line_w   = 32 * LINE_WORDS;
  localparam int c_index_w  = $clog2(DEPTH_LINES);
  localparam int c_offset_w = $clog2(4 * LINE_WORDS);
  localparam logic [3:0] c_load = 4'(LATENCY - 1);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_busy    = 2'd1;
  localparam logic [1:0] c_respond = 2'd2;
  localparam logic [1:0] c_drain   = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [3:0]           r_count;
  logic [c_index_w-1:0] r_index;
  logic                 r_wen;
  logic [c_line_w-1:0]  r_wdata;
  logic [c_line_w-1:0]  r_resp_data;
  logic [15:0]          r_txn_count;

  // Storage has no reset: contents survive rst.
  logic [c_line_w-1:0]  r_mem [DEPTH_LINES];

  logic [c_index_w-1:0] w_req_index;
  logic [c_index_w-1:0] w_sel_index;
  logic                 w_sel_wen;
  logic [c_line_w-1:0]  w_sel_wdata;
  logic                 w_enter_respond;
  logic                 w_commit;
  logic                 w_unused_addr;

  // Offset bits and bits above the index are deliberately dropped, so
  // addresses alias modulo the memory size.
  assign w_req_index   = reqAddress_MEM[c_offset_w +: c_index_w];
  assign w_unused_addr = ^reqAddress_MEM;

  // With LATENCY=1 the response is entered straight from IDLE, before the
  // request has been latched, so the live inputs are the source then.
  assign w_sel_index = (r_state == c_idle) ? w_req_index   : r_index;
  assign w_sel_wen   = (r_state == c_idle) ? reqWen_MEM    : r_wen;
  assign w_sel_wdata = (r_state == c_idle) ? reqDataIn_MEM : r_wdata;

  // RESPOND always leaves after one cycle, so next==RESPOND marks entry.
  assign w_enter_respond = (w_state_next == c_respond);
  // Gated by rst so an edge coinciding with reset can never commit a write.
  assign w_commit        = rst && w_enter_respond && w_sel_wen;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- next-state logic ----------------
  // The counter is loaded with LATENCY-1 and RESPOND is entered on the edge
  // where it reaches 0, so the pulse lands LATENCY cycles after acceptance.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      c_idle: begin
        if (reqValid_MEM) begin
          w_state_next = (LATENCY == 1) ? c_respond : c_busy;
        end
      end
      c_busy: begin
        if (r_count == 4'd1) begin
          w_state_next = c_respond;
        end
      end
      c_respond: w_state_next = c_drain;
      c_drain: begin
        // A request still held high here was already serviced.
        if (!reqValid_MEM) begin
          w_state_next = c_idle;
        end
      end
      default: w_state_next = c_idle;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    respReady_MEM = (r_state == c_respond);
  end

  assign respDataOut_MEM = r_resp_data;
  assign txnCount_MEM    = r_txn_count;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= 4'd0;
      r_index     <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_txn_count <= 16'd0;
    end else begin
      if (r_state == c_idle && reqValid_MEM) begin
        r_index <= w_req_index;
        r_wen   <= reqWen_MEM;
        r_wdata <= reqDataIn_MEM;
        r_count <= c_load;
      end else if (r_state == c_busy && r_count != 4'd0) begin
        r_count <= r_count - 4'd1;
      end
      // Response data is registered on RESPOND entry; a write echoes its
      // own data, so a read of the same line later sees the committed value.
      if (w_enter_respond) begin
        r_resp_data <= w_sel_wen ? w_sel_wdata : r_mem[w_sel_index];
      end
      if (r_state == c_respond) begin
        r_txn_count <= r_txn_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_sel_index] <= w_sel_wdata;
    end
  end

endmodule
`default_nettype wire

// File: doc/backing_memory.md
BACKING_MEMORY -- requirements
Module: backing_memory

Interface
REQ-001 Parameter: LINE_WORDS, default 4, number of 32-bit words per cache line; line width LW = 32*LINE_WORDS.
REQ-002 Parameter: DEPTH_LINES, default 256, number of lines stored (power of two).
REQ-003 Parameter: LATENCY, default 4, cycles from request acceptance to response (legal range 1..15).
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: reqValid_MEM  input  1  cache-side request valid, held high until response seen.
REQ-007 Port: reqAddress_MEM  input  32  byte address of line.
REQ-008 Port: reqWen_MEM  input  1  1 = line writeback, 0 = line fill.
REQ-009 Port: reqDataIn_MEM  input  LW  writeback line data.
REQ-010 Port: respDataOut_MEM  output  LW  fill line data.
REQ-011 Port: respReady_MEM  output  1  one-cycle completion pulse.
REQ-012 Port: txnCount_MEM  output  16  completed-transaction counter.

Function
REQ-013 Line index SHALL be reqAddress_MEM[log2(DEPTH_LINES)+log2(4*LINE_WORDS)-1 : log2(4*LINE_WORDS)]; lower offset bits ignored; upper bits ignored (aliasing wrap).
REQ-014 FSM states SHALL be IDLE, BUSY, RESPOND, DRAIN.
REQ-015 IDLE: reqValid_MEM=1 at edge N -> latch index, wen, data; load counter with LATENCY-1; go BUSY (or RESPOND directly if LATENCY=1).
REQ-016 BUSY: decrement counter each cycle; at counter 0 go RESPOND; inputs ignored while BUSY (latched copies used).
REQ-017 RESPOND: respReady_MEM=1 for exactly this cycle, which SHALL be cycle N+LATENCY.
REQ-018 RESPOND read: respDataOut_MEM = stored line at latched index, valid in RESPOND cycle and held until next RESPOND.
REQ-019 RESPOND write: latched data committed to line at the RESPOND edge; respDataOut_MEM = written data (write-through echo).
REQ-020 RESPOND -> DRAIN; txnCount_MEM increments by 1, wraps 0xFFFF -> 0x0000.
REQ-021 DRAIN: remain while reqValid_MEM=1; go IDLE on first cycle reqValid_MEM=0; a held valid SHALL never be serviced twice.
REQ-022 reqValid_MEM dropped during BUSY SHALL NOT abort transaction; response still issued, DRAIN exits next cycle.
REQ-023 Write to a line followed by read of same line SHALL return written data (no stale read).
REQ-024 Storage SHALL power up all-zero (simulation) and SHALL NOT be cleared by rst.

Reset
REQ-025 rst=0 SHALL asynchronously force state IDLE, counter 0, respReady_MEM=0, respDataOut_MEM=0, txnCount_MEM=0.
REQ-026 rst asserted in BUSY SHALL abort the transaction: no write committed, no response, no count increment.
REQ-027 After rst release, first request accepted at first rising edge with reqValid_MEM=1.

Verification
REQ-028 Fill of unwritten line: read 0x00000040 after reset -> respReady_MEM pulses exactly 4 cycles after acceptance, respDataOut_MEM=0, txnCount_MEM=1.
REQ-029 Writeback then fill: write 0x00000010 data {0x55739084,0x19475820,0x849292bb,0x002342ab}, drop valid, read 0x0000001C -> same 128-bit line returned.
REQ-030 Aliasing: write 0x00001000 (index 0, DEPTH 256) then read 0x00000000 -> written data returned.
REQ-031 Held valid: keep reqValid_MEM=1 for 20 cycles after response -> exactly one respReady_MEM pulse, txnCount_MEM +1 only.
REQ-032 Reset mid-write: assert rst 2 cycles into BUSY of write to 0x00000020 -> no pulse; later read 0x00000020 returns prior contents.
REQ-033 Counter wrap: 65536 back-to-back reads -> txnCount_MEM returns to 0x0000; LATENCY=1 build -> respReady_MEM on cycle after acceptance.
